// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register bank.
//   REG_W   : register width in bits
//   RW_BIT  : position of the read/write flag inside the slave's address byte
//   state_e : register-bank transaction state
package i2c_pkg;

  localparam int unsigned REG_W  = 8;
  localparam int unsigned RW_BIT = 0;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StGetPtr = 2'd1,
    StWrite  = 2'd2,
    StRead   = 2'd3
  } state_e;

endpackage

// File: rtl/i2c_reg_bank.sv
// Pointer-addressed byte register bank behind an I2C slave.
// An I2C write sets the pointer from its first data byte, and each later byte
// writes reg[ptr] and then advances ptr. An I2C read returns reg[ptr] and
// advances ptr each time the slave loads a byte. Read-only slots mirror regs_in.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   i2c_addr_rw(_valid_stb)  : matched address byte {addr, rw} and its strobe
//   i2c_data_rx(_valid_stb)  : received data byte and its strobe
//   i2c_data_tx              : next byte for the slave to transmit
//   i2c_data_tx_loaded_stb   : slave captured i2c_data_tx
//   i2c_data_tx_done_stb     : byte shifted out (informational)
//   i2c_error_stb            : bus error, aborts to idle
//   regs_in / regs_out       : status inputs for RO slots / bank contents
//   reg_wr_stb               : one-cycle pulse per written register
module i2c_reg_bank
  import i2c_pkg::*;
#(
  parameter int unsigned                   NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0]           RO_MASK    = '0,
  parameter logic [NUM_REGS*REG_W-1:0]     RESET_VALS = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_W-1:0]          i2c_addr_rw,
  input  logic                      i2c_addr_rw_valid_stb,
  input  logic [REG_W-1:0]          i2c_data_rx,
  input  logic                      i2c_data_rx_valid_stb,
  output logic [REG_W-1:0]          i2c_data_tx,
  input  logic                      i2c_data_tx_loaded_stb,
  input  logic                      i2c_data_tx_done_stb,
  input  logic                      i2c_error_stb,
  input  logic [NUM_REGS*REG_W-1:0] regs_in,
  output logic [NUM_REGS*REG_W-1:0] regs_out,
  output logic [NUM_REGS-1:0]       reg_wr_stb
);

  localparam int unsigned PTR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  state_e                state_q, state_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [REG_W-1:0]      tx_q, tx_d;
  logic                  pend_q, pend_d;  // reload tx from the advanced ptr
  logic [NUM_REGS-1:0]   wr_stb_q, wr_stb_d;
  logic [REG_W-1:0]      rd_byte [NUM_REGS];
  logic                  rw;

  assign rw = i2c_addr_rw[RW_BIT];

  // Only the rw bit of the address byte matters here; done is informational
  // and non-RO bytes of regs_in are ignored.
  logic unused_inputs;
  assign unused_inputs = ^{i2c_addr_rw, i2c_data_tx_done_stb, regs_in};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: error beats address, address beats data.
  always_comb begin
    state_d = state_q;
    if (i2c_error_stb) begin
      state_d = StIdle;
    end else if (i2c_addr_rw_valid_stb) begin
      state_d = rw ? StRead : StGetPtr;
    end else if (state_q == StGetPtr && i2c_data_rx_valid_stb) begin
      state_d = StWrite;
    end
  end

  // Pointer, transmit byte and write-strobe next values
  always_comb begin
    ptr_d    = ptr_q;
    tx_d     = tx_q;
    pend_d   = 1'b0;
    wr_stb_d = '0;
    if (i2c_error_stb) begin
      // abort: pointer and tx byte retained, no write
    end else if (i2c_addr_rw_valid_stb) begin
      if (rw) begin
        tx_d = rd_byte[ptr_q];
      end
    end else begin
      unique case (state_q)
        StGetPtr: begin
          if (i2c_data_rx_valid_stb) begin
            ptr_d = i2c_data_rx[PTR_W-1:0];
          end
        end
        StWrite: begin
          if (i2c_data_rx_valid_stb) begin
            if (!RO_MASK[ptr_q]) begin
              wr_stb_d[ptr_q] = 1'b1;
            end
            ptr_d = ptr_q + PTR_W'(1);
          end
        end
        StRead: begin
          if (pend_q) begin
            tx_d = rd_byte[ptr_q];
          end
          if (i2c_data_tx_loaded_stb) begin
            ptr_d  = ptr_q + PTR_W'(1);
            pend_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= '0;
      tx_q     <= '0;
      pend_q   <= 1'b0;
      wr_stb_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      tx_q     <= tx_d;
      pend_q   <= pend_d;
      wr_stb_q <= wr_stb_d;
    end
  end

  // Per-slot storage: RO slots have no flops and expose regs_in directly.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_slot
    if (RO_MASK[i]) begin : g_ro
      assign rd_byte[i] = regs_in[i*REG_W +: REG_W];
    end else begin : g_rw
      logic [REG_W-1:0] store_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          store_q <= RESET_VALS[i*REG_W +: REG_W];
        end else if (wr_stb_d[i]) begin
          store_q <= i2c_data_rx;
        end
      end
      assign rd_byte[i] = store_q;
    end
    assign regs_out[i*REG_W +: REG_W] = rd_byte[i];
  end

  assign i2c_data_tx = tx_q;
  assign reg_wr_stb  = wr_stb_q;

endmodule

// File: tb/tb_i2c_reg_bank.sv
module tb_i2c_reg_bank;

  localparam int unsigned N = 8;
  localparam logic [N*8-1:0] RST_VALS = 64'h0000_0000_00A5_0000;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [7:0]     addr_rw = '0;
  logic           addr_stb = 1'b0;
  logic [7:0]     rx = '0;
  logic           rx_stb = 1'b0;
  logic           loaded = 1'b0;
  logic           done = 1'b0;
  logic           err = 1'b0;
  logic [N*8-1:0] regs_in = '0;

  logic [7:0]     tx, tx_w;
  logic [N*8-1:0] regs_out, regs_out_w;
  logic [N-1:0]   wr_stb, wr_stb_w;

  i2c_reg_bank #(.NUM_REGS(N), .RO_MASK(8'h01), .RESET_VALS(RST_VALS)) dut (
    .clk(clk), .rst(rst),
    .i2c_addr_rw(addr_rw), .i2c_addr_rw_valid_stb(addr_stb),
    .i2c_data_rx(rx), .i2c_data_rx_valid_stb(rx_stb),
    .i2c_data_tx(tx), .i2c_data_tx_loaded_stb(loaded),
    .i2c_data_tx_done_stb(done), .i2c_error_stb(err),
    .regs_in(regs_in), .regs_out(regs_out), .reg_wr_stb(wr_stb)
  );

  // All-writable instance on the same bus, used to see wrap into slot 0.
  i2c_reg_bank #(.NUM_REGS(N), .RO_MASK(8'h00), .RESET_VALS(RST_VALS)) dut_w (
    .clk(clk), .rst(rst),
    .i2c_addr_rw(addr_rw), .i2c_addr_rw_valid_stb(addr_stb),
    .i2c_data_rx(rx), .i2c_data_rx_valid_stb(rx_stb),
    .i2c_data_tx(tx_w), .i2c_data_tx_loaded_stb(loaded),
    .i2c_data_tx_done_stb(done), .i2c_error_stb(err),
    .regs_in(regs_in), .regs_out(regs_out_w), .reg_wr_stb(wr_stb_w)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    int         idx;
    logic [7:0] data;
  } wr_t;
  wr_t        wr_q[$];
  logic [7:0] tx_q[$];

  typedef enum {MIdle, MGetPtr, MWrite, MRead} mstate_e;
  mstate_e    m_state;
  logic [7:0] m_ro [N];
  logic [7:0] m_rw [N];
  int         m_ptr;
  logic [7:0] m_tx;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rd_ro(input int i);
    return (i == 0) ? regs_in[7:0] : m_ro[i];
  endfunction

  function automatic logic [63:0] vec_ro();
    logic [63:0] v;
    for (int i = 0; i < N; i++) v[i*8 +: 8] = rd_ro(i);
    return v;
  endfunction

  function automatic logic [63:0] vec_rw();
    logic [63:0] v;
    for (int i = 0; i < N; i++) v[i*8 +: 8] = m_rw[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_ro[i] = RST_VALS[i*8 +: 8];
      m_rw[i] = RST_VALS[i*8 +: 8];
    end
    m_ptr   = 0;
    m_state = MIdle;
    m_tx    = 8'h00;
  endtask

  // Drive one cycle of strobes from a negedge, clear at the following negedge.
  task automatic step(input logic a_s, input logic [7:0] a, input logic r_s,
                      input logic [7:0] d, input logic ld, input logic dn, input logic er);
    @(negedge clk);
    addr_stb = a_s; addr_rw = a; rx_stb = r_s; rx = d;
    loaded = ld; done = dn; err = er;
    @(negedge clk);
    addr_stb = 1'b0; rx_stb = 1'b0; loaded = 1'b0; done = 1'b0; err = 1'b0;
  endtask

  task automatic pop_tx(input string tag);
    logic [7:0] e;
    e = tx_q.pop_front();
    check(tag, 64'(tx), 64'(e));
  endtask

  task automatic i2c_addr(input logic rw, input string tag);
    if (rw) begin
      m_state = MRead;
      m_tx    = rd_ro(m_ptr);
      tx_q.push_back(m_tx);
    end else begin
      m_state = MGetPtr;
    end
    step(1'b1, {7'h42, rw}, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    if (rw) pop_tx(tag);
  endtask

  task automatic i2c_rx(input logic [7:0] d);
    if (m_state == MGetPtr) begin
      m_ptr   = int'(d) % N;
      m_state = MWrite;
    end else if (m_state == MWrite) begin
      if (m_ptr != 0) begin
        m_ro[m_ptr] = d;
        wr_q.push_back('{idx: m_ptr, data: d});
      end
      m_rw[m_ptr] = d;
      m_ptr = (m_ptr + 1) % N;
    end
    step(1'b0, 8'h00, 1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  // Loaded strobe: tx holds one more cycle, then shows reg[ptr+1].
  task automatic tx_load(input string tag);
    m_ptr = (m_ptr + 1) % N;
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check({tag, "_hold"}, 64'(tx), 64'(m_tx));
    m_tx = rd_ro(m_ptr);
    tx_q.push_back(m_tx);
    @(negedge clk);
    pop_tx(tag);
  endtask

  // Write-strobe scoreboard: every strobed cycle pops one expected write.
  logic [N-1:0] mon_exp;
  wr_t          mon_e;
  always @(negedge clk) begin
    if (!rst && wr_stb !== '0) begin
      if (wr_q.size() > 0) begin
        mon_e   = wr_q.pop_front();
        mon_exp = N'(1) << mon_e.idx;
      end else begin
        mon_e   = '{idx: 0, data: 8'h00};
        mon_exp = '0;
      end
      checks++;
      assert (wr_stb === mon_exp) else begin
        errors++;
        $error("FAIL wr_stb: got %b expected %b", wr_stb, mon_exp);
      end
      if (mon_exp != '0) begin
        checks++;
        assert (regs_out[mon_e.idx*8 +: 8] === mon_e.data) else begin
          errors++;
          $error("FAIL wr_data reg%0d: got %h expected %h", mon_e.idx,
                 regs_out[mon_e.idx*8 +: 8], mon_e.data);
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_regs", regs_out, vec_ro());
    check("rst_regs_w", regs_out_w, vec_rw());
    check("rst_tx", 64'(tx), 64'h00);
    check("rst_tx_w", 64'(tx_w), 64'h00);
    check("rst_stb", 64'(wr_stb), 64'h0);
    check("rst_stb_w", 64'(wr_stb_w), 64'h0);

    // Pointer 3, then two data bytes
    i2c_addr(1'b0, "");
    i2c_rx(8'h03); i2c_rx(8'h11); i2c_rx(8'h22);
    @(negedge clk);
    check("wr34_regs", regs_out, vec_ro());
    check("wr34_stb_idle", 64'(wr_stb), 64'h0);
    i2c_addr(1'b1, "rd_ptr5");

    // Pointer-only write, then read with auto-increment
    i2c_addr(1'b0, ""); i2c_rx(8'h03);
    i2c_addr(1'b1, "rd_reg3");
    tx_load("rd_reg4");

    // Wrap from slot 7 into slot 0 (RO on dut, writable on dut_w)
    regs_in[7:0] = 8'hFF;
    i2c_addr(1'b0, "");
    i2c_rx(8'h07); i2c_rx(8'hAA); i2c_rx(8'hBB); i2c_rx(8'hCC);
    @(negedge clk);
    check("wrap_regs", regs_out, vec_ro());
    check("wrap_regs_w", regs_out_w, vec_rw());

    // Upper pointer bits ignored: 0xF9 selects slot 1
    i2c_addr(1'b0, ""); i2c_rx(8'hF9); i2c_rx(8'h3C);
    @(negedge clk);
    check("ptr_f9_regs", regs_out, vec_ro());

    // Read-only slot 0 ignores writes; write continues to slot 1
    i2c_addr(1'b0, ""); i2c_rx(8'h00); i2c_rx(8'h00); i2c_rx(8'h5C);
    @(negedge clk);
    check("ro_regs", regs_out, vec_ro());
    check("ro_regs_w", regs_out_w, vec_rw());
    i2c_addr(1'b0, ""); i2c_rx(8'h00);
    i2c_addr(1'b1, "rd_ro0");
    tx_load("rd_reg1");

    // Done strobe must not advance the pointer
    i2c_addr(1'b0, ""); i2c_rx(8'h06);
    i2c_addr(1'b1, "rd_reg6");
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("done_tx_hold", 64'(tx), 64'(m_tx));
    tx_load("rd_reg7");

    // Error coincident with rx in WRITE: no write, back to idle, ptr kept
    i2c_addr(1'b0, ""); i2c_rx(8'h02);
    m_state = MIdle;
    step(1'b0, 8'h00, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
    i2c_rx(8'h66);
    @(negedge clk);
    check("err_regs", regs_out, vec_ro());
    i2c_addr(1'b1, "err_rd_reg2");

    // Address coincident with rx: rx dropped, state restarts in GET_PTR
    i2c_addr(1'b0, ""); i2c_rx(8'h03);
    m_state = MGetPtr;
    step(1'b1, 8'h84, 1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    i2c_rx(8'h04); i2c_rx(8'h44);
    @(negedge clk);
    check("addr_rx_regs", regs_out, vec_ro());

    // Reset mid-WRITE with a coincident rx byte
    i2c_addr(1'b0, ""); i2c_rx(8'h05); i2c_rx(8'h55);
    @(negedge clk);
    rst = 1'b1; rx_stb = 1'b1; rx = 8'h66;
    @(negedge clk);
    rst = 1'b0; rx_stb = 1'b0;
    model_reset();
    check("midrst_regs", regs_out, vec_ro());
    check("midrst_regs_w", regs_out_w, vec_rw());
    check("midrst_tx", 64'(tx), 64'h00);
    check("midrst_stb", 64'(wr_stb), 64'h0);
    i2c_addr(1'b1, "midrst_rd_ptr0");

    repeat (2) @(negedge clk);
    check("wr_q_empty", 64'(wr_q.size()), 64'd0);
    check("tx_q_empty", 64'(tx_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
